// File: rtl/fifo_stream_checker.sv
// In-line reference checker for the synchronous FIFO: shadow model, per-cycle compare, saturating counters.
// Optional first-error capture is built when FIFO_STREAM_CHECKER_FIRST_ERR_EN is defined.
module fifo_stream_checker #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          check_en,
   input  logic                          dut_rst_n,
   input  logic                          wr_en,
   input  logic                          rd_en,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic [DATA_WIDTH-1:0]         data_out,
   input  logic                          wr_ack,
   input  logic                          overflow,
   input  logic                          underflow,
   input  logic                          full,
   input  logic                          almostfull,
   input  logic                          empty,
   input  logic                          almostempty,
   output logic                          mismatch,
   output logic [7:0]                    err_code,
   output logic [CNT_WIDTH-1:0]          correct_count,
   output logic [CNT_WIDTH-1:0]          error_count,
   output logic [$clog2(FIFO_DEPTH):0]   model_count,
   output logic                          first_err_valid,
   output logic [CNT_WIDTH-1:0]          first_err_cycle,
   output logic [7:0]                    first_err_code
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   localparam logic [OCC_W-1:0]     DEPTH_C  = OCC_W'(FIFO_DEPTH);
   localparam logic [OCC_W-1:0]     DEPTH_M1 = OCC_W'(FIFO_DEPTH - 1);
   localparam logic [OCC_W-1:0]     ONE_OCC  = OCC_W'(1);
   localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [PTR_W-1:0]     ONE_PTR  = PTR_W'(1);
   localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + ONE_CNT;
   endfunction

   // Explicit wrap so non-power-of-two depths stay modulo FIFO_DEPTH
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + ONE_PTR;
   endfunction

   logic [DATA_WIDTH-1:0] shadow [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;

   logic                  exp_wr_ack_p1, exp_overflow_p1, exp_underflow_p1;
   logic [DATA_WIDTH-1:0] exp_data_p1;
   logic                  vld_p1;

   logic       full_m, empty_m, wr_acc_p0, rd_acc_p0, chk_p0;
   logic [7:0] err_vec_p0;

   // Stage p0: accept decisions and error vector for the current sample
   always_comb begin
      full_m     = (model_count == DEPTH_C);
      empty_m    = (model_count == '0);
      wr_acc_p0  = wr_en && !full_m;
      rd_acc_p0  = rd_en && !empty_m;
      chk_p0     = check_en && dut_rst_n;
      err_vec_p0 = '0;
      err_vec_p0[0] = vld_p1 && (data_out != exp_data_p1);
      err_vec_p0[1] = (wr_ack != exp_wr_ack_p1);
      err_vec_p0[2] = (overflow != exp_overflow_p1);
      err_vec_p0[3] = (underflow != exp_underflow_p1);
      err_vec_p0[4] = (full != full_m);
      err_vec_p0[5] = (almostfull != (model_count == DEPTH_M1));
      err_vec_p0[6] = (empty != empty_m);
      err_vec_p0[7] = (almostempty != (model_count == ONE_OCC));
   end

   // Stage p1: reference model state and expected registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         model_count      <= '0;
         exp_wr_ack_p1    <= 1'b0;
         exp_overflow_p1  <= 1'b0;
         exp_underflow_p1 <= 1'b0;
         exp_data_p1      <= '0;
         vld_p1           <= 1'b0;
      end else if (!dut_rst_n) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         model_count      <= '0;
         exp_wr_ack_p1    <= 1'b0;
         exp_overflow_p1  <= 1'b0;
         exp_underflow_p1 <= 1'b0;
         exp_data_p1      <= '0;
         vld_p1           <= 1'b0;
      end else begin
         if (wr_acc_p0) wr_ptr <= ptr_next(wr_ptr);
         if (rd_acc_p0) rd_ptr <= ptr_next(rd_ptr);
         case ({wr_acc_p0, rd_acc_p0})
            2'b10:   model_count <= model_count + ONE_OCC;
            2'b01:   model_count <= model_count - ONE_OCC;
            default: model_count <= model_count;
         endcase
         exp_wr_ack_p1    <= wr_acc_p0;
         exp_overflow_p1  <= wr_en && full_m;
         exp_underflow_p1 <= rd_en && empty_m;
         vld_p1           <= rd_acc_p0;
         if (rd_acc_p0) exp_data_p1 <= shadow[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (dut_rst_n && wr_acc_p0) shadow[wr_ptr] <= data_in;
   end

   // Stage p1: registered verdict and saturating tallies
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mismatch      <= 1'b0;
         err_code      <= '0;
         correct_count <= '0;
         error_count   <= '0;
      end else if (chk_p0) begin
         mismatch <= |err_vec_p0;
         err_code <= err_vec_p0;
         if (|err_vec_p0) error_count   <= sat_inc(error_count);
         else             correct_count <= sat_inc(correct_count);
      end else begin
         mismatch <= 1'b0;
      end
   end

`ifdef FIFO_STREAM_CHECKER_FIRST_ERR_EN
   logic [CNT_WIDTH-1:0] cycle_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt       <= '0;
         first_err_valid <= 1'b0;
         first_err_cycle <= '0;
         first_err_code  <= '0;
      end else begin
         cycle_cnt <= sat_inc(cycle_cnt);
         if (chk_p0 && (|err_vec_p0) && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_cycle <= cycle_cnt;
            first_err_code  <= err_vec_p0;
         end
      end
   end
`else
   assign first_err_valid = 1'b0;
   assign first_err_cycle = '0;
   assign first_err_code  = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_checker.sv
// Bench for fifo_stream_checker: plays the FIFO from a queue model, injects faults, predicts the checker's verdicts.
module tb_fifo_stream_checker;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst, check_en, dut_rst_n, wr_en, rd_en;
   logic [15:0] data_in, data_out;
   logic        wr_ack, overflow, underflow, full, almostfull, empty, almostempty;

   logic        mismatch, first_err_valid;
   logic [7:0]  err_code, first_err_code;
   logic [31:0] correct_count, error_count, first_err_cycle;
   logic [3:0]  model_count;

   logic        s_mismatch, s_first_err_valid;
   logic [7:0]  s_err_code, s_first_err_code;
   logic [3:0]  s_correct_count, s_error_count, s_first_err_cycle;
   logic [3:0]  s_model_count;

   always #5 clk = ~clk;

   fifo_stream_checker #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(32)) u_dut (
      .clk(clk), .rst(rst), .check_en(check_en), .dut_rst_n(dut_rst_n),
      .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
      .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
      .full(full), .almostfull(almostfull), .empty(empty), .almostempty(almostempty),
      .mismatch(mismatch), .err_code(err_code),
      .correct_count(correct_count), .error_count(error_count), .model_count(model_count),
      .first_err_valid(first_err_valid), .first_err_cycle(first_err_cycle),
      .first_err_code(first_err_code));

   fifo_stream_checker #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(4)) u_sat (
      .clk(clk), .rst(rst), .check_en(check_en), .dut_rst_n(dut_rst_n),
      .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
      .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
      .full(full), .almostfull(almostfull), .empty(empty), .almostempty(almostempty),
      .mismatch(s_mismatch), .err_code(s_err_code),
      .correct_count(s_correct_count), .error_count(s_error_count), .model_count(s_model_count),
      .first_err_valid(s_first_err_valid), .first_err_cycle(s_first_err_cycle),
      .first_err_code(s_first_err_code));

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural FIFO played by the bench, plus predicted checker state
   logic [15:0] q[$];
   logic        f_wr_ack, f_ovf, f_unf, prev_rd_acc;
   logic [15:0] f_dout;
   int          n_ok, n_err, cyc;
   logic        exp_mis, exp_fv;
   logic [7:0]  exp_err, exp_fcode;
   int          exp_fcyc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int sat4(input int n);
      return (n > 15) ? 15 : n;
   endfunction

   task automatic clear_model();
      q.delete();
      f_wr_ack = 1'b0; f_ovf = 1'b0; f_unf = 1'b0; f_dout = '0; prev_rd_acc = 1'b0;
   endtask

   task automatic clear_expect();
      n_ok = 0; n_err = 0; cyc = 0;
      exp_mis = 1'b0; exp_err = '0; exp_fv = 1'b0; exp_fcode = '0; exp_fcyc = 0;
   endtask

   task automatic check_outputs();
      chk("mismatch", mismatch, exp_mis);
      chk("err_code", err_code, exp_err);
      chk("correct_count", correct_count, n_ok);
      chk("error_count", error_count, n_err);
      chk("model_count", model_count, q.size());
      chk("sat_correct", s_correct_count, sat4(n_ok));
      chk("sat_error", s_error_count, sat4(n_err));
`ifdef FIFO_STREAM_CHECKER_FIRST_ERR_EN
      chk("first_valid", first_err_valid, exp_fv);
      chk("first_cycle", first_err_cycle, exp_fcyc);
      chk("first_code", first_err_code, exp_fcode);
`else
      chk("first_valid", first_err_valid, 1'b0);
      chk("first_cycle", first_err_cycle, 32'd0);
      chk("first_code", first_err_code, 8'd0);
`endif
   endtask

   // One FIFO cycle: present observed signals (with optional faults), clock, update model, check
   task automatic step(input logic wr, input logic rd, input logic [15:0] din, input logic [7:0] inj);
      int         sz;
      logic       wacc, racc, chkd;
      logic [7:0] vec;
      sz          = q.size();
      wr_en       = wr;
      rd_en       = rd;
      data_in     = din;
      data_out    = f_dout ^ 16'(inj[0]);
      wr_ack      = f_wr_ack ^ inj[1];
      overflow    = f_ovf ^ inj[2];
      underflow   = f_unf ^ inj[3];
      full        = (sz == DEPTH) ^ inj[4];
      almostfull  = (sz == DEPTH - 1) ^ inj[5];
      empty       = (sz == 0) ^ inj[6];
      almostempty = (sz == 1) ^ inj[7];
      chkd = check_en && dut_rst_n;
      // A corrupted data_out only counts when a read was accepted the cycle before
      vec  = inj & {7'h7f, prev_rd_acc};
      if (chkd) begin
         exp_err = vec;
         exp_mis = |vec;
         if (|vec) begin
            n_err++;
            if (!exp_fv) begin
               exp_fv = 1'b1; exp_fcyc = cyc; exp_fcode = vec;
            end
         end else begin
            n_ok++;
         end
      end else begin
         exp_mis = 1'b0;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (!dut_rst_n) begin
         clear_model();
      end else begin
         wacc = wr && (sz != DEPTH);
         racc = rd && (sz != 0);
         f_wr_ack = wacc;
         f_ovf    = wr && (sz == DEPTH);
         f_unf    = rd && (sz == 0);
         if (racc) f_dout = q.pop_front();
         if (wacc) q.push_back(din);
         prev_rd_acc = racc;
      end
      check_outputs();
   endtask

   initial begin
      logic [31:0] hold_ok, hold_err;
      logic [7:0]  inj;
      rst = 1'b1; check_en = 1'b1; dut_rst_n = 1'b1;
      wr_en = 1'b0; rd_en = 1'b0; data_in = '0; data_out = '0;
      wr_ack = 1'b0; overflow = 1'b0; underflow = 1'b0;
      full = 1'b0; almostfull = 1'b0; empty = 1'b1; almostempty = 1'b0;
      clear_model();
      clear_expect();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;

      // Fill to full, one overflowing write, drain in order
      for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 16'(16'h1111 * k), 8'h00);
      chk("full_after_8", model_count, 4'd8);
      step(1'b1, 1'b0, 16'hDEAD, 8'h00);
      chk("overflow_no_store", model_count, 4'd8);
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 16'h0000, 8'h00);
      step(1'b0, 1'b0, 16'h0000, 8'h00);
      chk("clean_errors", error_count, 32'd0);
      chk("clean_17plus", (correct_count >= 32'd17), 1'b1);
      chk("sat_holds_f", s_correct_count, 4'hF);

      // Underflow, then simultaneous request from empty
      step(1'b0, 1'b1, 16'h0000, 8'h00);
      step(1'b1, 1'b1, 16'hA5A5, 8'h00);
      chk("both_from_empty", model_count, 4'd1);
      step(1'b0, 1'b0, 16'h0000, 8'h00);

      // Five entries, corrupt the data returned by the 3rd read
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 16'(16'h0100 + k), 8'h00);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 16'h0000, 8'h00);
      step(1'b0, 1'b0, 16'h0000, 8'h01);
      chk("inj_mismatch", mismatch, 1'b1);
      chk("inj_err_code", err_code, 8'h01);
      chk("inj_error_count", error_count, 32'd1);
      step(1'b0, 1'b0, 16'h0000, 8'h00);
      chk("inj_pulse_ends", mismatch, 1'b0);

      // FIFO reset pulse with five entries held
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'(16'h0200 + k), 8'h00);
      chk("five_held", model_count, 4'd5);
      hold_ok = correct_count; hold_err = error_count;
      dut_rst_n = 1'b0;
      step(1'b0, 1'b0, 16'h0000, 8'h40);
      chk("dutrst_count", model_count, 4'd0);
      chk("dutrst_ok_hold", correct_count, hold_ok);
      chk("dutrst_err_hold", error_count, hold_err);
      dut_rst_n = 1'b1;
      step(1'b0, 1'b0, 16'h0000, 8'h00);

      // Compare disabled: faults ignored, verdicts hold
      check_en = 1'b0;
      step(1'b1, 1'b0, 16'h3333, 8'h12);
      chk("chkoff_mismatch", mismatch, 1'b0);
      check_en = 1'b1;

      // Randomised traffic with occasional faults, gaps and FIFO resets
      for (int i = 0; i < 300; i++) begin
         inj = 8'h00;
         if ($urandom_range(11) == 0) inj = 8'(1 << $urandom_range(7));
         check_en  = ($urandom_range(7) != 0);
         dut_rst_n = ($urandom_range(39) != 0);
         step(1'($urandom_range(1)), 1'($urandom_range(1)), 16'($urandom), inj);
      end
      check_en = 1'b1; dut_rst_n = 1'b1;

      // Asynchronous checker reset in the middle of a cycle, FIFO reset alongside
      step(1'b1, 1'b0, 16'h7777, 8'h00);
      #3;
      rst = 1'b1;
      clear_model();
      clear_expect();
      #1;
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 20; i++)
         step(1'($urandom_range(1)), 1'($urandom_range(1)), 16'($urandom), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_stream_checker.md
Name: fifo_stream_checker

Overview:
- Synthesizable, parametrised in-line checker for the synchronous FIFO; next generation of the bench-side monitor/scoreboard pair.
- Passively taps every FIFO port, runs a cycle-accurate reference model (shadow memory, pointers, occupancy) and compares all DUT outputs each cycle.
- Keeps saturating pass/fail counters and a per-check mismatch bitmap, so the same block serves simulation, emulation and FPGA bring-up.

Parameters:
- DATA_WIDTH, 16, width of data_in/data_out
- FIFO_DEPTH, 8, DUT depth in entries; must be >= 4
- CNT_WIDTH, 32, width of correct_count/error_count

Ports:
- clk  in  1  checker clock; same clock as the FIFO
- rst  in  1  asynchronous active-high reset of the checker
- check_en  in  1  1 = compare and count; 0 = model tracks, no compare, no count
- dut_rst_n  in  1  observed FIFO reset, active-low
- wr_en, rd_en  in  1 each  observed FIFO requests
- data_in  in  DATA_WIDTH  observed write data
- data_out  in  DATA_WIDTH  observed read data
- wr_ack, overflow, underflow  in  1 each  observed registered status
- full, almostfull, empty, almostempty  in  1 each  observed combinational flags
- mismatch  out  1  pulse for one cycle when any check failed
- err_code  out  8  failing checks: [0] data_out, [1] wr_ack, [2] overflow, [3] underflow, [4] full, [5] almostfull, [6] empty, [7] almostempty
- correct_count  out  CNT_WIDTH  checked cycles with no failure
- error_count  out  CNT_WIDTH  checked cycles with one or more failures
- model_count  out  $clog2(FIFO_DEPTH)+1  reference occupancy
- first_err_valid  out  1  first error captured (optional feature)
- first_err_cycle  out  CNT_WIDTH  cycle stamp of first error (optional feature)
- first_err_code  out  8  err_code of first error (optional feature)

Behaviour:
- rst=1, asynchronous: all outputs, pointers, model_count, cycle stamp and expected registers go to 0.
- Model accept rules, evaluated on each posedge clk:
  - Write accepted when wr_en && !full_m.
  - Read accepted when rd_en && !empty_m.
  - Both requested: when empty_m, only the write is accepted; when full_m, only the read is accepted; otherwise both are accepted.
  - Occupancy: write only +1, read only -1, both 0.
  - Pointers wrap modulo FIFO_DEPTH.
- Expected registered outputs, valid the cycle after the request:
  - exp_wr_ack = write accepted.
  - exp_overflow = wr_en && full_m.
  - exp_underflow = rd_en && empty_m.
  - exp_data = shadow[rd_ptr], compared only when a read was accepted the previous cycle.
- Expected flags, from the current model_count:
  - full = (count == FIFO_DEPTH)
  - almostfull = (count == FIFO_DEPTH-1)
  - empty = (count == 0)
  - almostempty = (count == 1)
- Checking, per cycle, when check_en=1 and dut_rst_n=1:
  - Compute the 8-bit error vector.
  - On the next edge, register it into err_code; set mismatch = |vector.
  - Increment error_count if any bit is set, else increment correct_count.
- Latency: a failure is visible on mismatch/err_code one cycle after the bad sample.
- Counters saturate at all-ones and do not wrap.
- dut_rst_n=0, sampled synchronously: clear pointers, count and expected registers; skip compare; counters hold; mismatch=0. Flags must read empty=1 from the first cycle after release.
- check_en=0: model still tracks, mismatch=0, err_code holds, counters hold.
- rst asserted mid-traffic: everything clears immediately; the model restarts empty. It does not resynchronise to a non-empty DUT, so the bench must reset both together.

Optional Feature:
FIFO_STREAM_CHECKER_FIRST_ERR_EN
- Defined:
  - A free-running cycle counter (saturating, CNT_WIDTH) runs.
  - On the first failing checked cycle, capture first_err_cycle and first_err_code and set first_err_valid.
  - The capture is sticky until rst.
- Undefined: the three first_err_* ports are present but tied to 0, and no capture logic is generated.

Test Plan:
- Reset, then check_en=1, write 0x1111..0x8888 (8 writes, DEPTH 8), then 8 reads -> data_out matches in order; full=1 after the 8th write; correct_count=17+, error_count=0.
- From full, one extra write with data 0xDEAD -> overflow=1 next cycle, no storage; the next read returns 0x1111.
- From empty, rd_en=1 -> underflow=1; simultaneous wr_en+rd_en from empty -> only the write happens, model_count=1, almostempty=1.
- Inject a bad data_out (bit 0 flipped) on the 3rd read -> mismatch=1 with err_code=8'h01 one cycle later; error_count=1; with the macro defined, first_err_valid=1 and first_err_code=8'h01.
- Pulse dut_rst_n low with 5 entries held -> model_count=0; empty expected 1 next cycle; counters unchanged during the low cycle.
- Force correct_count near saturation (CNT_WIDTH=4, 20 clean cycles) -> holds at 4'hF, no wrap.
